vpu_issue_ctrl: RTL and testbench
=================================

VPU_ISSUE_CTRL -- requirements
Module: vpu_issue_ctrl

Interface
REQ-001 Parameters (name, default, meaning) SHALL be:
- R_PORTS, 3, SRAM read ports.
- ADDR_W, 8, SRAM address width.
- OPC_W, 7, opcode width.
- DLY_W, 4, decoder delay width.
- SUB_W, 2, reduction sub-delay width.
- FUNC_W, 32, opaque op_func width.
REQ-002 Ports (name, direction, width, meaning) SHALL be:
- clk, in, 1, clock.
- rst_n, in, 1, reset: synchronous, active-low.
- req_valid_i, in, 1, decoded request valid.
- req_ready_o, out, 1, block can accept a request.
- req_rvalid_i, in, R_PORTS, source-operand port mask.
- req_raddr_i, in, R_PORTS*ADDR_W, source addresses; port k occupies bits [k*ADDR_W +: ADDR_W].
- req_waddr_i, in, ADDR_W, destination address.
- req_delay_i, in, DLY_W, execution delay.
- req_red_i, in, 1, reduction op.
- req_sub_delay_i, in, SUB_W, reduction extra delay.
- req_opcode_i, in, OPC_W, opcode.
- req_op_func_i, in, FUNC_W, execution-unit select.
- sram_rd_en_o, out, R_PORTS, per-port read strobe.
- sram_raddr_o, out, R_PORTS*ADDR_W, read addresses.
- exec_valid_o, out, 1, operands valid to execution unit.
- exec_op_func_o, out, FUNC_W, latched op_func.
- exec_opcode_o, out, OPC_W, latched opcode.
- sram_wr_en_o, out, 1, write-back request.
- sram_waddr_o, out, ADDR_W, write address.
- sram_wr_ready_i, in, 1, write accepted.
- done_o, out, 1, one-cycle completion pulse.
- busy_cycles_o, out, 32, performance counter.

Function
REQ-003 The FSM SHALL have states IDLE, READ, WAIT, WRITE, and SHALL drive req_ready_o=1 only in IDLE.
REQ-004 Handshake on req_valid_i&&req_ready_o at cycle T SHALL latch all req_* inputs and go to READ at T+1; if the latched rvalid mask is 0, it SHALL instead stay in IDLE, with no reads, no write and no done_o (NOP).
REQ-005 READ SHALL last one cycle and drive sram_rd_en_o=latched mask and sram_raddr_o=latched addresses; unmasked ports SHALL have rd_en=0.
REQ-006 On entry to WAIT (cycle T+2), exec_valid_o SHALL be 1 for exactly one cycle, and the counter SHALL load N = delay + (red ? sub_delay : 0) at DLY_W+1 bits without overflow.
REQ-007 WAIT SHALL last N+1 cycles: if counter==0, go to WRITE; else decrement; WRITE SHALL be entered at T+3+N.
REQ-008 WRITE SHALL hold sram_wr_en_o=1 with sram_waddr_o=latched waddr until sram_wr_ready_i=1; in that cycle done_o SHALL be 1, and the next cycle SHALL be IDLE.
REQ-009 exec_op_func_o/exec_opcode_o SHALL hold latched values from READ until IDLE, and SHALL be 0 in IDLE.
REQ-010 sram_raddr_o and sram_waddr_o SHALL be 0 whenever their enables are 0.
REQ-011 Requests presented outside IDLE SHALL NOT be latched, and req_* changes after acceptance SHALL have no effect.
REQ-012 Back-to-back: a request valid in the first IDLE cycle after WRITE SHALL be accepted that cycle.

Reset
REQ-013 rst_n=0 at a clock edge SHALL force IDLE, clear the counter and latches, and drive all outputs to 0 except req_ready_o=1 in the following cycle.
REQ-014 Reset mid-operation (any non-IDLE state) SHALL drop the in-flight op with no write or done_o.

Configuration
REQ-015 With VPU_ISSUE_PERF_CNT_EN defined, busy_cycles_o SHALL increment every cycle the FSM is not IDLE, saturate at 2^32-1, and clear on reset.
REQ-016 Without VPU_ISSUE_PERF_CNT_EN, busy_cycles_o SHALL be constant 0 and no counter logic is instantiated.

Verification
REQ-017 mask=3'b011, delay=2, red=0, wr_ready=1 -> rd_en=011 at T+1, exec_valid at T+2, wr_en at T+5, done_o at T+5, ready at T+6.
REQ-018 mask=3'b001, delay=2, red=1, sub_delay=2 -> N=4, wr_en at T+7; with PERF_EN, busy_cycles_o=7 after completion.
REQ-019 mask=3'b111, delay=0; wr_ready low 3 cycles then high -> wr_en held 4 cycles with waddr stable, single done_o pulse.
REQ-020 mask=3'b000 -> no rd_en, exec_valid, wr_en or done_o; req_ready_o stays 1.
REQ-021 rst_n low during WAIT -> next cycle IDLE with all outputs 0 and ready=1; no wr_en ever appears for the dropped op.
REQ-022 Two back-to-back ops with delay=1 and req_valid_i held high -> second accepted in the cycle after first done_o; waddr values are distinct and correct.

Source files
------------

// File: rtl/vpu_issue_ctrl.sv
// Single-op issue controller for the VPU: reads operands, waits out the execution delay, writes back.
// Optional busy-cycle performance counter enabled by defining VPU_ISSUE_PERF_CNT_EN.
module vpu_issue_ctrl #(
  parameter int R_PORTS = 3,
  parameter int ADDR_W  = 8,
  parameter int OPC_W   = 7,
  parameter int DLY_W   = 4,
  parameter int SUB_W   = 2,
  parameter int FUNC_W  = 32
) (
  input  logic                      clk,
  input  logic                      rst_n,
  input  logic                      req_valid_i,
  output logic                      req_ready_o,
  input  logic [R_PORTS-1:0]        req_rvalid_i,
  input  logic [R_PORTS*ADDR_W-1:0] req_raddr_i,
  input  logic [ADDR_W-1:0]         req_waddr_i,
  input  logic [DLY_W-1:0]          req_delay_i,
  input  logic                      req_red_i,
  input  logic [SUB_W-1:0]          req_sub_delay_i,
  input  logic [OPC_W-1:0]          req_opcode_i,
  input  logic [FUNC_W-1:0]         req_op_func_i,
  output logic [R_PORTS-1:0]        sram_rd_en_o,
  output logic [R_PORTS*ADDR_W-1:0] sram_raddr_o,
  output logic                      exec_valid_o,
  output logic [FUNC_W-1:0]         exec_op_func_o,
  output logic [OPC_W-1:0]          exec_opcode_o,
  output logic                      sram_wr_en_o,
  output logic [ADDR_W-1:0]         sram_waddr_o,
  input  logic                      sram_wr_ready_i,
  output logic                      done_o,
  output logic [31:0]               busy_cycles_o
);

  // state   | meaning
  // IDLE    | ready for a request; mask==0 requests are swallowed as NOPs
  // READ    | one-cycle SRAM read of the masked source ports
  // WAIT    | execution delay countdown (N+1 cycles)
  // WRITE   | hold write-back until the SRAM accepts it
  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_READ  = 2'd1,
    ST_WAIT  = 2'd2,
    ST_WRITE = 2'd3
  } state_t;

  localparam int CNT_W = DLY_W + 1;

  state_t                      r_state;
  logic                        r_ready;
  logic [R_PORTS-1:0]          r_rd_en;
  logic [R_PORTS*ADDR_W-1:0]   r_raddr;
  logic                        r_exec_valid;
  logic [FUNC_W-1:0]           r_op_func;
  logic [OPC_W-1:0]            r_opcode;
  logic                        r_wr_en;
  logic [ADDR_W-1:0]           r_waddr_o;
  logic [ADDR_W-1:0]           r_waddr;
  logic [DLY_W-1:0]            r_delay;
  logic                        r_red;
  logic [SUB_W-1:0]            r_sub_delay;
  logic [CNT_W-1:0]            r_cnt;

  logic                        w_accept;
  logic                        w_has_reads;
  logic [R_PORTS*ADDR_W-1:0]   w_raddr_masked;
  logic [CNT_W-1:0]            w_load_n;

  assign w_accept    = req_valid_i && r_ready;
  assign w_has_reads = |req_rvalid_i;

  always_comb begin
    w_raddr_masked = '0;
    for (int p = 0; p < R_PORTS; p++) begin
      if (req_rvalid_i[p]) begin
        w_raddr_masked[p*ADDR_W +: ADDR_W] = req_raddr_i[p*ADDR_W +: ADDR_W];
      end
    end
  end

  // One extra bit keeps delay + sub_delay from wrapping.
  assign w_load_n = CNT_W'(r_delay) + (r_red ? CNT_W'(r_sub_delay) : CNT_W'(0));

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_state      <= ST_IDLE;
      r_ready      <= 1'b1;
      r_rd_en      <= '0;
      r_raddr      <= '0;
      r_exec_valid <= 1'b0;
      r_op_func    <= '0;
      r_opcode     <= '0;
      r_wr_en      <= 1'b0;
      r_waddr_o    <= '0;
      r_waddr      <= '0;
      r_delay      <= '0;
      r_red        <= 1'b0;
      r_sub_delay  <= '0;
      r_cnt        <= '0;
    end else begin
      r_exec_valid <= 1'b0;
      case (r_state)
        ST_IDLE: begin
          if (w_accept) begin
            r_waddr     <= req_waddr_i;
            r_delay     <= req_delay_i;
            r_red       <= req_red_i;
            r_sub_delay <= req_sub_delay_i;
            if (w_has_reads) begin
              r_state   <= ST_READ;
              r_ready   <= 1'b0;
              r_rd_en   <= req_rvalid_i;
              r_raddr   <= w_raddr_masked;
              r_op_func <= req_op_func_i;
              r_opcode  <= req_opcode_i;
            end
          end
        end
        ST_READ: begin
          r_state      <= ST_WAIT;
          r_rd_en      <= '0;
          r_raddr      <= '0;
          r_exec_valid <= 1'b1;
          r_cnt        <= w_load_n;
        end
        ST_WAIT: begin
          if (r_cnt == '0) begin
            r_state   <= ST_WRITE;
            r_wr_en   <= 1'b1;
            r_waddr_o <= r_waddr;
          end else begin
            r_cnt <= r_cnt - CNT_W'(1);
          end
        end
        ST_WRITE: begin
          if (sram_wr_ready_i) begin
            r_state   <= ST_IDLE;
            r_ready   <= 1'b1;
            r_wr_en   <= 1'b0;
            r_waddr_o <= '0;
            r_op_func <= '0;
            r_opcode  <= '0;
          end
        end
        default: begin
          r_state <= ST_IDLE;
          r_ready <= 1'b1;
        end
      endcase
    end
  end

  assign req_ready_o    = r_ready;
  assign sram_rd_en_o   = r_rd_en;
  assign sram_raddr_o   = r_raddr;
  assign exec_valid_o   = r_exec_valid;
  assign exec_op_func_o = r_op_func;
  assign exec_opcode_o  = r_opcode;
  assign sram_wr_en_o   = r_wr_en;
  assign sram_waddr_o   = r_waddr_o;
  assign done_o         = r_wr_en && sram_wr_ready_i;

`ifdef VPU_ISSUE_PERF_CNT_EN
  logic [31:0] r_busy_cycles;

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_busy_cycles <= '0;
    end else if ((r_state != ST_IDLE) && (r_busy_cycles != 32'hFFFF_FFFF)) begin
      r_busy_cycles <= r_busy_cycles + 32'd1;
    end
  end

  assign busy_cycles_o = r_busy_cycles;
`else
  assign busy_cycles_o = 32'd0;
`endif

endmodule

// File: tb/tb_vpu_issue_ctrl.sv
// Self-checking bench for vpu_issue_ctrl: directed scenarios plus randomized ops against
// a per-op timeline model (accept at k=0, read at k=1, exec at k=2, write from k=N+3).
module tb_vpu_issue_ctrl;
  localparam int R_PORTS = 3;
  localparam int ADDR_W  = 8;
  localparam int OPC_W   = 7;
  localparam int DLY_W   = 4;
  localparam int SUB_W   = 2;
  localparam int FUNC_W  = 32;
  localparam int VEC_W   = 1 + R_PORTS + R_PORTS*ADDR_W + 1 + FUNC_W + OPC_W + 1 + ADDR_W + 1;

  typedef struct {
    logic [R_PORTS-1:0]        mask;
    logic [R_PORTS*ADDR_W-1:0] raddr;
    logic [ADDR_W-1:0]         waddr;
    logic [DLY_W-1:0]          delay;
    logic                      red;
    logic [SUB_W-1:0]          sub;
    logic [OPC_W-1:0]          opc;
    logic [FUNC_W-1:0]         func;
    int                        wlat;
  } op_t;

  logic                      clk = 1'b0;
  logic                      rst_n;
  logic                      req_valid_i;
  logic                      req_ready_o;
  logic [R_PORTS-1:0]        req_rvalid_i;
  logic [R_PORTS*ADDR_W-1:0] req_raddr_i;
  logic [ADDR_W-1:0]         req_waddr_i;
  logic [DLY_W-1:0]          req_delay_i;
  logic                      req_red_i;
  logic [SUB_W-1:0]          req_sub_delay_i;
  logic [OPC_W-1:0]          req_opcode_i;
  logic [FUNC_W-1:0]         req_op_func_i;
  logic [R_PORTS-1:0]        sram_rd_en_o;
  logic [R_PORTS*ADDR_W-1:0] sram_raddr_o;
  logic                      exec_valid_o;
  logic [FUNC_W-1:0]         exec_op_func_o;
  logic [OPC_W-1:0]          exec_opcode_o;
  logic                      sram_wr_en_o;
  logic [ADDR_W-1:0]         sram_waddr_o;
  logic                      sram_wr_ready_i;
  logic                      done_o;
  logic [31:0]               busy_cycles_o;

  int          n_cmp = 0;
  int          n_bad = 0;
  logic [31:0] busy_exp = 32'd0;

  vpu_issue_ctrl #(
    .R_PORTS(R_PORTS), .ADDR_W(ADDR_W), .OPC_W(OPC_W),
    .DLY_W(DLY_W), .SUB_W(SUB_W), .FUNC_W(FUNC_W)
  ) dut (
    .clk(clk), .rst_n(rst_n),
    .req_valid_i(req_valid_i), .req_ready_o(req_ready_o),
    .req_rvalid_i(req_rvalid_i), .req_raddr_i(req_raddr_i),
    .req_waddr_i(req_waddr_i), .req_delay_i(req_delay_i),
    .req_red_i(req_red_i), .req_sub_delay_i(req_sub_delay_i),
    .req_opcode_i(req_opcode_i), .req_op_func_i(req_op_func_i),
    .sram_rd_en_o(sram_rd_en_o), .sram_raddr_o(sram_raddr_o),
    .exec_valid_o(exec_valid_o), .exec_op_func_o(exec_op_func_o),
    .exec_opcode_o(exec_opcode_o), .sram_wr_en_o(sram_wr_en_o),
    .sram_waddr_o(sram_waddr_o), .sram_wr_ready_i(sram_wr_ready_i),
    .done_o(done_o), .busy_cycles_o(busy_cycles_o)
  );

  always #5 clk = ~clk;

  function automatic logic [VEC_W-1:0] observed();
    return {req_ready_o, sram_rd_en_o, sram_raddr_o, exec_valid_o, exec_op_func_o,
            exec_opcode_o, sram_wr_en_o, sram_waddr_o, done_o};
  endfunction

  function automatic logic [31:0] busy_model();
`ifdef VPU_ISSUE_PERF_CNT_EN
    return busy_exp;
`else
    return 32'd0;
`endif
  endfunction

  // The IDLE picture: only ready is high.
  function automatic logic [VEC_W-1:0] idle_vec();
    logic [VEC_W-1:0] v;
    v = '0;
    v[VEC_W-1] = 1'b1;
    return v;
  endfunction

  task automatic scramble_req(input logic [R_PORTS-1:0] mask);
    req_rvalid_i    = mask;
    req_raddr_i     = (R_PORTS*ADDR_W)'($urandom);
    req_waddr_i     = ADDR_W'($urandom);
    req_delay_i     = DLY_W'($urandom);
    req_red_i       = 1'($urandom);
    req_sub_delay_i = SUB_W'($urandom);
    req_opcode_i    = OPC_W'($urandom);
    req_op_func_i   = $urandom;
  endtask

  function automatic op_t rand_op();
    op_t o;
    o.mask  = R_PORTS'($urandom_range(1, (1 << R_PORTS) - 1));
    o.raddr = (R_PORTS*ADDR_W)'($urandom);
    o.waddr = ADDR_W'($urandom);
    o.delay = DLY_W'($urandom);
    o.red   = 1'($urandom);
    o.sub   = SUB_W'($urandom);
    o.opc   = OPC_W'($urandom);
    o.func  = $urandom;
    o.wlat  = $urandom_range(0, 3);
    return o;
  endfunction

  function automatic op_t mk_op(input logic [R_PORTS-1:0] mask, input int delay, input logic red,
                                input int sub, input logic [ADDR_W-1:0] waddr, input int wlat);
    op_t o;
    o = rand_op();
    o.mask  = mask;
    o.delay = DLY_W'(delay);
    o.red   = red;
    o.sub   = SUB_W'(sub);
    o.waddr = waddr;
    o.wlat  = wlat;
    return o;
  endfunction

  // Drives one op from its accept cycle (k=0) through its done cycle, checking every cycle.
  task automatic exec_op(input op_t op, input bit hold_valid, input string tag);
    int n;
    int total;
    logic [R_PORTS*ADDR_W-1:0] masked;
    logic [VEC_W-1:0] exp_v;
    logic [VEC_W-1:0] got_v;
    n = int'(op.delay) + (op.red ? int'(op.sub) : 0);
    total = n + 3 + op.wlat;
    masked = '0;
    for (int p = 0; p < R_PORTS; p++)
      if (op.mask[p]) masked[p*ADDR_W +: ADDR_W] = op.raddr[p*ADDR_W +: ADDR_W];
    for (int k = 0; k <= total; k++) begin
      @(posedge clk); #1;
      if (k == 0) begin
        req_valid_i     = 1'b1;
        req_rvalid_i    = op.mask;
        req_raddr_i     = op.raddr;
        req_waddr_i     = op.waddr;
        req_delay_i     = op.delay;
        req_red_i       = op.red;
        req_sub_delay_i = op.sub;
        req_opcode_i    = op.opc;
        req_op_func_i   = op.func;
      end else begin
        req_valid_i = hold_valid ? 1'b1 : 1'($urandom);
        scramble_req(R_PORTS'($urandom));
      end
      sram_wr_ready_i = (k >= n + 3) ? (k == total) : 1'($urandom);
      @(negedge clk);
      exp_v = {(k == 0),
               (k == 1) ? op.mask : {R_PORTS{1'b0}},
               (k == 1) ? masked : {(R_PORTS*ADDR_W){1'b0}},
               (k == 2),
               (k >= 1) ? op.func : {FUNC_W{1'b0}},
               (k >= 1) ? op.opc : {OPC_W{1'b0}},
               (k >= n + 3),
               (k >= n + 3) ? op.waddr : {ADDR_W{1'b0}},
               (k == total)};
      got_v = observed();
      n_cmp++;
      if (got_v !== exp_v) begin
        n_bad++;
        $display("FAIL %s k=%0d outputs got %h exp %h", tag, k, got_v, exp_v);
      end
      if (k == 0) begin
        n_cmp++;
        if (busy_cycles_o !== busy_model()) begin
          n_bad++;
          $display("FAIL %s busy_cycles got %0d exp %0d", tag, busy_cycles_o, busy_model());
        end
      end
    end
    busy_exp = busy_exp + 32'(total);
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    req_valid_i = 1'b1;
    sram_wr_ready_i = 1'b1;
    scramble_req('1);
    for (int c = 0; c < 3; c++) begin
      @(posedge clk); #1;
      scramble_req('1);
      @(negedge clk);
      n_cmp++;
      if (observed() !== idle_vec()) begin
        n_bad++;
        $display("FAIL reset outputs got %h exp %h", observed(), idle_vec());
      end
      n_cmp++;
      if (busy_cycles_o !== 32'd0) begin
        n_bad++;
        $display("FAIL reset busy got %0d exp 0", busy_cycles_o);
      end
    end
    @(posedge clk); #1;
    rst_n = 1'b1;
    req_valid_i = 1'b0;
    busy_exp = 32'd0;
  endtask

  task automatic test_directed();
    exec_op(mk_op(3'b001, 2, 1'b1, 2, 8'h5A, 0), 1'b0, "red_sub_delay");
    exec_op(mk_op(3'b011, 2, 1'b0, 3, 8'h3C, 0), 1'b0, "basic_delay2");
    exec_op(mk_op(3'b111, 0, 1'b0, 0, 8'hC3, 3), 1'b0, "wr_backpressure");
    exec_op(mk_op(3'b100, 15, 1'b1, 3, 8'hFF, 1), 1'b0, "max_delay");
  endtask

  task automatic test_nop();
    for (int c = 0; c < 6; c++) begin
      @(posedge clk); #1;
      req_valid_i = 1'b1;
      scramble_req('0);
      sram_wr_ready_i = 1'($urandom);
      @(negedge clk);
      n_cmp++;
      if (observed() !== idle_vec()) begin
        n_bad++;
        $display("FAIL nop outputs got %h exp %h", observed(), idle_vec());
      end
      n_cmp++;
      if (busy_cycles_o !== busy_model()) begin
        n_bad++;
        $display("FAIL nop busy got %0d exp %0d", busy_cycles_o, busy_model());
      end
    end
  endtask

  task automatic test_back_to_back();
    exec_op(mk_op(3'b010, 1, 1'b0, 0, 8'h11, 0), 1'b1, "b2b_first");
    exec_op(mk_op(3'b101, 1, 1'b0, 0, 8'h22, 0), 1'b1, "b2b_second");
    exec_op(mk_op(3'b110, 1, 1'b0, 0, 8'h33, 1), 1'b0, "b2b_third");
  endtask

  task automatic test_random();
    for (int i = 0; i < 30; i++) begin
      int gap;
      gap = $urandom_range(0, 2);
      for (int g = 0; g < gap; g++) begin
        @(posedge clk); #1;
        req_valid_i = 1'($urandom);
        scramble_req('0);
        sram_wr_ready_i = 1'($urandom);
        @(negedge clk);
        n_cmp++;
        if (observed() !== idle_vec()) begin
          n_bad++;
          $display("FAIL rand_gap op=%0d outputs got %h exp %h", i, observed(), idle_vec());
        end
      end
      exec_op(rand_op(), 1'($urandom), "random");
    end
  endtask

  task automatic test_reset_mid();
    op_t op;
    op = mk_op(3'b101, 5, 1'b0, 0, 8'h77, 0);
    for (int k = 0; k <= 3; k++) begin
      @(posedge clk); #1;
      if (k == 0) begin
        req_valid_i     = 1'b1;
        req_rvalid_i    = op.mask;
        req_raddr_i     = op.raddr;
        req_waddr_i     = op.waddr;
        req_delay_i     = op.delay;
        req_red_i       = op.red;
        req_sub_delay_i = op.sub;
        req_opcode_i    = op.opc;
        req_op_func_i   = op.func;
      end else begin
        scramble_req('1);
      end
      sram_wr_ready_i = 1'b1;
      if (k == 3) rst_n = 1'b0;
      @(negedge clk);
      if (k == 1) begin
        n_cmp++;
        if (sram_rd_en_o !== op.mask) begin
          n_bad++;
          $display("FAIL reset_mid rd_en got %b exp %b", sram_rd_en_o, op.mask);
        end
      end
      if (k == 2) begin
        n_cmp++;
        if (exec_valid_o !== 1'b1) begin
          n_bad++;
          $display("FAIL reset_mid exec_valid got %b exp 1", exec_valid_o);
        end
      end
    end
    busy_exp = 32'd0;
    for (int c = 0; c < 10; c++) begin
      @(posedge clk); #1;
      rst_n = 1'b1;
      req_valid_i = 1'b0;
      sram_wr_ready_i = 1'b1;
      @(negedge clk);
      n_cmp++;
      if (observed() !== idle_vec()) begin
        n_bad++;
        $display("FAIL reset_mid c=%0d outputs got %h exp %h", c, observed(), idle_vec());
      end
      n_cmp++;
      if (busy_cycles_o !== 32'd0) begin
        n_bad++;
        $display("FAIL reset_mid busy got %0d exp 0", busy_cycles_o);
      end
    end
  endtask

  initial begin
    rst_n = 1'b0;
    req_valid_i = 1'b0;
    sram_wr_ready_i = 1'b0;
    scramble_req('0);
    test_reset();
    test_directed();
    test_nop();
    test_back_to_back();
    test_random();
    test_reset_mid();
    test_random();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
